// File: rtl/pifo_pkg.sv
// Package: pifo_pkg
// Shared field widths, bit offsets and record layouts for the per-port PIFO.
// The rank calculator uses the same offsets to pack tuples and to unpack the
// last-packet-info word, so these constants must stay in step on both sides.
//   Tuple / entry word : {port_id[2:0], class[4:0], round[19:0], tag[3:0]}
//   Last-packet-info   : {round[19:0], class[4:0], occupancy[6:0]}
package pifo_pkg;

    localparam int PIFO_ROUND_W = 20;
    localparam int PIFO_CLASS_W = 5;
    localparam int PIFO_PORT_W  = 3;
    localparam int PIFO_TAG_W   = 4;
    localparam int PIFO_INFO_W  = 7;
    localparam int PIFO_DROP_W  = 16;
    localparam int PIFO_ENTRY_W = PIFO_PORT_W + PIFO_CLASS_W + PIFO_ROUND_W + PIFO_TAG_W;

    // Entry word bit offsets
    localparam int PIFO_TAG_LSB   = 0;
    localparam int PIFO_ROUND_LSB = PIFO_TAG_LSB + PIFO_TAG_W;
    localparam int PIFO_CLASS_LSB = PIFO_ROUND_LSB + PIFO_ROUND_W;
    localparam int PIFO_PORT_LSB  = PIFO_CLASS_LSB + PIFO_CLASS_W;

    // Last-packet-info word bit offsets
    localparam int PIFO_INFO_OCC_LSB   = 0;
    localparam int PIFO_INFO_CLASS_LSB = PIFO_INFO_OCC_LSB + PIFO_INFO_W;
    localparam int PIFO_INFO_ROUND_LSB = PIFO_INFO_CLASS_LSB + PIFO_CLASS_W;

    typedef struct packed {
        logic [PIFO_PORT_W-1:0]  port_id;
        logic [PIFO_CLASS_W-1:0] cls;
        logic [PIFO_ROUND_W-1:0] round;
        logic [PIFO_TAG_W-1:0]   tag;
    } pifo_entry_t;

    typedef struct packed {
        logic [PIFO_ROUND_W-1:0] round;
        logic [PIFO_CLASS_W-1:0] cls;
        logic [PIFO_INFO_W-1:0]  occupancy;
    } pifo_last_info_t;

endpackage

// File: rtl/pifo_port_queue_if.sv
// Interface: pifo_port_queue_if
// Tuple ingress strobe and head-of-queue dequeue handshake for one PIFO port.
//   tuple_in_rank_VALID / tuple_in_rank_DATA : rank tuple, no back-pressure
//   deq_valid / deq_data / deq_ready         : head entry, popped on valid & ready
// Modports: master = tuple producer and dequeue consumer, slave = the PIFO.
interface pifo_port_queue_if
    import pifo_pkg::*;
#(
    parameter int ENTRY_W = PIFO_ENTRY_W
);

    logic               tuple_in_rank_VALID;
    logic [ENTRY_W-1:0] tuple_in_rank_DATA;
    logic               deq_valid;
    logic [ENTRY_W-1:0] deq_data;
    logic               deq_ready;

    modport master (
        output tuple_in_rank_VALID,
        output tuple_in_rank_DATA,
        output deq_ready,
        input  deq_valid,
        input  deq_data
    );

    modport slave (
        input  tuple_in_rank_VALID,
        input  tuple_in_rank_DATA,
        input  deq_ready,
        output deq_valid,
        output deq_data
    );

endinterface

// File: rtl/pifo_round_cmp.sv
// Module: pifo_round_cmp
// Combinational "a is not after b" round compare used to build the insertion
// thermometer: le = 1 when an entry with round a must stay ahead of a new
// entry with round b (equal rounds stay ahead, giving FIFO tie-break).
//   a  : round of an existing entry
//   b  : round of the incoming tuple
//   le : a <= b in the compiled ordering
// Build option PIFO_WRAP_CMP_EN: serial-number ordering, b < a iff (b - a)
// mod 2^ROUND_WIDTH has its MSB set; otherwise plain unsigned compare.
module pifo_round_cmp
    import pifo_pkg::*;
#(
    parameter int ROUND_WIDTH = PIFO_ROUND_W
)(
    input  logic [ROUND_WIDTH-1:0] a,
    input  logic [ROUND_WIDTH-1:0] b,
    output logic                   le
);

`ifdef PIFO_WRAP_CMP_EN
    logic [ROUND_WIDTH-1:0] diff;

    // a <= b  <=>  not (b < a)  <=>  MSB of (b - a) clear
    assign diff = b - a;
    assign le   = ~diff[ROUND_WIDTH-1];
`else
    assign le = (a <= b);
`endif

endmodule

// File: rtl/pifo_port_queue.sv
// Module: pifo_port_queue
// Per-output-port PIFO fed by the WFQ rank calculator. Entries are kept sorted
// by round in a shift-register array whose slot 0 is the head; the smallest
// round pops on downstream demand and every pop publishes a last-packet-info
// word back to the rank calculator.
// Ports:
//   clk_dp                 datapath clock
//   rst                    asynchronous reset, active low
//   q_if (slave)           tuple ingress and head dequeue handshake
//   wire_out_last_pkt_info {popped round, popped class, occupancy after pop}
//   wire_out_occupancy     current entry count (saturated to INFO_WIDTH)
//   wire_out_drop_cnt      saturating count of tuples dropped while full
// Build option PIFO_WRAP_CMP_EN selects wrap-safe round ordering (see
// pifo_round_cmp); undefined gives plain unsigned ordering.
module pifo_port_queue
    import pifo_pkg::*;
#(
    parameter int PORT_ID        = 0,
    parameter int DEPTH          = 16,
    parameter int ROUND_WIDTH    = PIFO_ROUND_W,
    parameter int CLASS_WIDTH    = PIFO_CLASS_W,
    parameter int PORT_ID_WIDTH  = PIFO_PORT_W,
    parameter int TAG_WIDTH      = PIFO_TAG_W,
    parameter int INFO_WIDTH     = PIFO_INFO_W,
    parameter int DROP_CNT_WIDTH = PIFO_DROP_W
)(
    input  logic                                        clk_dp,
    input  logic                                        rst,
    pifo_port_queue_if.slave                            q_if,
    output logic [ROUND_WIDTH+CLASS_WIDTH+INFO_WIDTH-1:0] wire_out_last_pkt_info,
    output logic [INFO_WIDTH-1:0]                       wire_out_occupancy,
    output logic [DROP_CNT_WIDTH-1:0]                   wire_out_drop_cnt
);

    localparam int ENTRY_W   = PORT_ID_WIDTH + CLASS_WIDTH + ROUND_WIDTH + TAG_WIDTH;
    localparam int ROUND_LSB = TAG_WIDTH;
    localparam int CLASS_LSB = ROUND_LSB + ROUND_WIDTH;
    localparam int PORT_LSB  = CLASS_LSB + CLASS_WIDTH;
    localparam int INFO_TOT  = ROUND_WIDTH + CLASS_WIDTH + INFO_WIDTH;
    localparam int OCC_W     = $clog2(DEPTH + 1);
    localparam int OCC_SAT   = (2 ** INFO_WIDTH) - 1;

    function automatic logic [INFO_WIDTH-1:0] sat_occ(input logic [OCC_W-1:0] o);
        if (int'(o) > OCC_SAT) return '1;
        return INFO_WIDTH'(o);
    endfunction

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
        if (&v) return v;
        return v + DROP_CNT_WIDTH'(1);
    endfunction

    logic [ENTRY_W-1:0]     ent_q [DEPTH];
    logic [ENTRY_W-1:0]     ent_s [DEPTH];
    logic [ENTRY_W-1:0]     ent_n [DEPTH];
    logic [DEPTH-1:0]       valid_q;
    logic [DEPTH-1:0]       valid_s;
    logic [DEPTH-1:0]       valid_n;
    logic [DEPTH-1:0]       le_vec;
    logic [DEPTH-1:0]       thermo;
    logic [OCC_W-1:0]       occ_q;
    logic [OCC_W-1:0]       occ_n;
    logic [INFO_TOT-1:0]    last_info_q;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

    logic [ENTRY_W-1:0]     new_ent;
    logic [ROUND_WIDTH-1:0] new_round;
    logic                   port_match;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;

    assign new_ent    = q_if.tuple_in_rank_DATA;
    assign new_round  = new_ent[ROUND_LSB +: ROUND_WIDTH];
    assign port_match = q_if.tuple_in_rank_VALID
                      & (new_ent[PORT_LSB +: PORT_ID_WIDTH] == PORT_ID_WIDTH'(PORT_ID));
    assign full       = (occ_q == OCC_W'(DEPTH));
    // A pop frees a slot in the same cycle, so a full queue still accepts.
    assign pop        = valid_q[0] & q_if.deq_ready;
    assign push       = port_match & (~full | pop);
    assign drop       = port_match & full & ~pop;

    always_comb begin
        occ_n = occ_q;
        case ({push, pop})
            2'b10:   occ_n = occ_q + OCC_W'(1);
            2'b01:   occ_n = occ_q - OCC_W'(1);
            default: occ_n = occ_q;
        endcase
    end

    // Per slot: apply the pop shift first, then compare the shifted entry
    // against the new round. thermo is a prefix of ones marking entries that
    // stay ahead; the first zero slot takes the new entry and everything behind
    // it moves one slot toward the tail.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == DEPTH - 1) begin : g_tail
            assign ent_s[i]   = pop ? '0   : ent_q[i];
            assign valid_s[i] = pop ? 1'b0 : valid_q[i];
        end else begin : g_body
            assign ent_s[i]   = pop ? ent_q[i+1]   : ent_q[i];
            assign valid_s[i] = pop ? valid_q[i+1] : valid_q[i];
        end

        pifo_round_cmp #(
            .ROUND_WIDTH (ROUND_WIDTH)
        ) u_cmp (
            .a  (ent_s[i][ROUND_LSB +: ROUND_WIDTH]),
            .b  (new_round),
            .le (le_vec[i])
        );

        assign thermo[i] = valid_s[i] & le_vec[i];

        if (i == 0) begin : g_head
            assign ent_n[i]   = (~push | thermo[i]) ? ent_s[i]   : new_ent;
            assign valid_n[i] = (~push | thermo[i]) ? valid_s[i] : 1'b1;
        end else begin : g_rest
            assign ent_n[i]   = (~push | thermo[i]) ? ent_s[i]
                              : (thermo[i-1] ? new_ent : ent_s[i-1]);
            assign valid_n[i] = (~push | thermo[i]) ? valid_s[i]
                              : (thermo[i-1] | valid_s[i-1]);
        end
    end

    always_ff @(posedge clk_dp or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            valid_q     <= '0;
            occ_q       <= '0;
            last_info_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_n[i];
            valid_q <= valid_n;
            occ_q   <= occ_n;
            if (pop) begin
                last_info_q <= {ent_q[0][ROUND_LSB +: ROUND_WIDTH],
                                ent_q[0][CLASS_LSB +: CLASS_WIDTH],
                                sat_occ(occ_n)};
            end
            if (drop) drop_cnt_q <= sat_inc(drop_cnt_q);
        end
    end

    assign q_if.deq_valid      = valid_q[0];
    assign q_if.deq_data       = ent_q[0];
    assign wire_out_last_pkt_info = last_info_q;
    assign wire_out_occupancy  = sat_occ(occ_q);
    assign wire_out_drop_cnt   = drop_cnt_q;

endmodule
